uart_tx: RTL
============

# uart_tx

Buffered UART transmitter. It serialises one byte per frame onto `tx` using the same frame format and configuration inputs as the team's UART receiver: 7/8 data bits, optional parity with four modes, and 1 or 2 stop bits. Bit timing comes from the shared external UART clock generator, which this block gates through `uart_enable`. A one-entry holding register lets the next byte be queued while a frame is on the line, so consecutive frames go out with no idle gap.

## Interface
Parameters: none.

- `clk`  in  1  system clock; all registers are on its rising edge
- `rst`  in  1  reset, synchronous, active-low
- `clk_uart`  in  1  bit-rate clock from the external generator, sampled in the `clk` domain
- `uart_enable`  out  1  run request to the generator
- `data_size`  in  1  0: 7 data bits; 1: 8 data bits
- `parity_en`  in  1  1: insert a parity bit
- `parity_mode`  in  2  11 odd, 10 even, 01 mark (1), 00 space (0)
- `stop_bit_size`  in  1  0: 1 stop bit; 1: 2 stop bits
- `data`  in  8  byte to send; in 7-bit mode `data[7]` is ignored
- `send`  in  1  write strobe, qualified by `ready`
- `ready`  out  1  holding register empty, so a write is accepted
- `busy`  out  1  a frame is on the line (state ≠ IDLE)
- `done`  out  1  one-`clk` pulse at the end of each frame's last stop bit
- `tx`  out  1  serial line, idle high

## Operation
- **Edge detection:** `clk_uart_d` registers `clk_uart`. `uart_tick = clk_uart & ~clk_uart_d`. Every state and `tx` update happens only in a `clk` cycle where `uart_tick` is high.
- **Holding register (`hold`, `hold_valid`):**
  - `ready = ~hold_valid`.
  - `send & ready` latches `data` and sets `hold_valid`.
  - `send` while `ready` is low is ignored; the held byte is unchanged.
- **Frame engine states:** IDLE, START, DATA, PARITY, STOP. The state names the bit currently driven on `tx`.
- **Load:**
  - In IDLE with `hold_valid`, or in STOP at the final tick with `hold_valid`, the next tick does the following:
    - `tx`←0 and state←START.
    - Shift register ←`hold`.
    - `data_size`, `parity_en`, `parity_mode` and `stop_bit_size` are latched for the whole frame.
    - `hold_valid` is cleared.
  - A clear and a write never coincide, because a write needs an empty holding register and a load needs a full one.
- **Transitions, one per tick:**
  - START→DATA, bit counter=0, `tx`=d[0].
  - DATA: `tx`=d[cnt], LSB first. At cnt=N−1 (N=7 or 8) go to PARITY if parity is enabled, else to STOP.
  - PARITY: `tx`=p, then STOP.
  - STOP: `tx`=1, counter 0, then 1 if 2 stop bits are configured. At the final stop tick, `done` pulses and the engine either loads (see above) or goes to IDLE.
- **Parity bit:** p = `parity_mode[0]` ^ (`parity_mode[1]` & XOR of the N data bits). Odd, even, mark and space follow from this.
- **Frame length:** 1 + N + `parity_en` + (1 + `stop_bit_size`) bit periods.
- **Generator control:** `uart_enable = hold_valid | busy`. It drops in the cycle after the engine returns to IDLE with the holding register empty.
- **Configuration changes:** changes mid-frame take effect at the next load only.
- **Reset (`rst`=0 at a `clk` edge):**
  - State IDLE, `hold_valid`=0, counter 0, `clk_uart_d`=0.
  - Output values: `tx`=1, `ready`=1, `busy`=0, `done`=0, `uart_enable`=0.
- **Reset mid-frame:** the frame is aborted, `tx` is high from the next cycle, and the queued byte is discarded.

## Timing
- `tx`, state and `done` change one `clk` after a `clk_uart` rising edge (the registered-tick latency). Each bit lasts exactly one `clk_uart` period.
- After an accepted `send`:
  - `ready` goes low on the next `clk`.
  - With the engine idle, the start bit begins at the first `uart_tick` after `uart_enable` rises.
  - `ready` returns high one `clk` after that tick.
- **Back-to-back frames:** a byte written before the final stop tick produces a start bit immediately after the last stop bit, with zero idle bits.
- `done` and the load of the next frame occur in the same cycle.
- `busy` is high from the start tick through the final stop tick, inclusive.

## Test plan
- **8N1 single byte:** `data`=0xA5, `data_size`=1, `parity_en`=0, `stop_bit_size`=0, then `send`. `tx` per bit period must be 0,1,0,1,0,0,1,0,1,1. Then `done` pulses once, `busy` falls, `uart_enable` falls and `tx` stays 1.
- **7E2:** 0x41 with even parity and 2 stop bits gives 0,1,0,0,0,0,0,1,0,1,1 (parity 0). The same byte with odd parity gives a parity bit of 1. 8-bit 0x00 with mark parity gives 1; with space parity, 0.
- **Queueing and back-to-back:** send 0x55, wait for `ready` high, send 0x0F before the first frame ends. The two frames must be contiguous with no idle bit, `done` must pulse twice, and `ready` must be high after the second load.
- **Write while full:** with `hold_valid` set, pulse `send` with 0xFF. 0xFF must never appear on `tx`, and the held byte must be transmitted unchanged.
- **Reset mid-frame:** assert `rst`=0 during data bit 3. On the next cycle `tx` must be 1, `ready`=1, `busy`=0 and `uart_enable`=0, and no frame resumes after release.
- **Config change mid-frame:** toggle `parity_en` and `data_size` during a frame. The current frame length must be unchanged, and the next frame must use the new settings.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake, frame configuration, bit-rate clock and serial line of uart_tx.
`timescale 1ns/1ps
interface uart_tx_if;
    logic       clk_uart;
    logic       uart_enable;
    logic       data_size;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic       stop_bit_size;
    logic [7:0] data;
    logic       send;
    logic       ready;
    logic       busy;
    logic       done;
    logic       tx;
    modport master (
        output clk_uart, data_size, parity_en, parity_mode, stop_bit_size, data, send,
        input  uart_enable, ready, busy, done, tx
    );
    modport slave (
        input  clk_uart, data_size, parity_en, parity_mode, stop_bit_size, data, send,
        output uart_enable, ready, busy, done, tx
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, 7/8 data bits, optional parity, 1/2 stop bits,
// with a one-byte holding register so queued frames follow each other with no idle gap.
`timescale 1ns/1ps
module uart_tx (
    input logic    clk,
    input logic    rst,
    uart_tx_if.slave u
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t     state, state_n;
    logic       clk_uart_d, tick, hold_valid, load;
    logic       tx_q, tx_n, done_q, done_n;
    logic       size_q, par_en_q, par_q, stop_q;
    logic [2:0] cnt, cnt_n;
    logic [7:0] hold, sh;
    assign tick          = u.clk_uart & ~clk_uart_d;
    assign u.ready       = ~hold_valid;
    assign u.busy        = state != IDLE;
    assign u.done        = done_q;
    assign u.tx          = tx_q;
    assign u.uart_enable = hold_valid | u.busy;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            cnt        <= 3'd0;
            clk_uart_d <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            hold_valid <= ~load & (hold_valid | u.send);
            cnt        <= cnt_n;
            clk_uart_d <= u.clk_uart;
            tx_q       <= tx_n;
            done_q     <= done_n;
        end
    end
    // Frame configuration and parity are frozen at load so mid-frame changes only affect the next frame.
    always_ff @(posedge clk) begin
        if (u.send && !hold_valid) hold <= u.data;
        if (load) begin
            sh       <= hold;
            size_q   <= u.data_size;
            par_en_q <= u.parity_en;
            stop_q   <= u.stop_bit_size;
            par_q    <= u.parity_mode[0] ^ (u.parity_mode[1] & (u.data_size ? ^hold : ^hold[6:0]));
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tx_n    = tx_q;
        done_n  = 1'b0;
        load    = 1'b0;
        if (tick) begin
            case (state)
                IDLE:    load = hold_valid;
                START: begin
                    state_n = DATA;
                    cnt_n   = 3'd0;
                    tx_n    = sh[0];
                end
                DATA: begin
                    if (cnt == (size_q ? 3'd7 : 3'd6)) begin
                        state_n = par_en_q ? PARITY : STOP;
                        cnt_n   = 3'd0;
                        tx_n    = par_en_q ? par_q : 1'b1;
                    end else begin
                        cnt_n = cnt + 3'd1;
                        tx_n  = sh[cnt_n];
                    end
                end
                PARITY: begin
                    state_n = STOP;
                    cnt_n   = 3'd0;
                    tx_n    = 1'b1;
                end
                STOP: begin
                    tx_n = 1'b1;
                    if (cnt == {2'b00, stop_q}) begin
                        done_n  = 1'b1;
                        load    = hold_valid;
                        state_n = IDLE;
                    end else begin
                        cnt_n = 3'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (load) begin
                state_n = START;
                cnt_n   = 3'd0;
                tx_n    = 1'b0;
            end
        end
    end
endmodule
